// File: rtl/xclk_strobe_tx_pkg.sv
// xclk_strobe_tx_pkg: state encodings and defaults shared by both ends of the strobe crossing
package xclk_strobe_tx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int CNT_W_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/xclk_sync_bit.sv
// xclk_sync_bit: multi-flop level synchronizer for a single asynchronous bit
module xclk_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("xclk_sync_bit needs at least 2 stages");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/xclk_strobe_tx.sv
// xclk_strobe_tx: source side of a toggle-handshake strobe crossing with a saturating backlog counter
module xclk_strobe_tx
    import xclk_strobe_tx_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_stb,
    output logic             xreq,
    input  logic             xack,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    input  logic             stat_clr,
    output logic             overflow,
    output logic             err
);

    state_e           state_q, state_d;
    logic             xreq_q, xreq_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
    logic             ack_s;
    logic             launch;
    logic             stray;
    logic [CNT_W:0]   sum;

    xclk_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xack),
        .q     (ack_s)
    );

    // sum cannot underflow: launch only fires when pending!=0 or in_stb
    always_comb begin
        launch     = (state_q == ST_IDLE) && ((pending_q != '0) || in_stb);
        sum        = {1'b0, pending_q} + (CNT_W+1)'(in_stb) - (CNT_W+1)'(launch);
        pending_d  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        xreq_d     = xreq_q ^ launch;
        state_d    = launch ? ST_WAIT :
                     ((state_q == ST_WAIT) && (ack_s == xreq_q)) ? ST_IDLE : state_q;
        stray      = (state_q == ST_IDLE) && (ack_s != xreq_q);
        overflow_d = sum[CNT_W] | (overflow_q & ~stat_clr);
        err_d      = stray | (err_q & ~stat_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            xreq_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            xreq_q     <= xreq_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign xreq     = xreq_q;
    assign pending  = pending_q;
    assign busy     = (state_q == ST_WAIT) || (pending_q != '0);
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_xclk_strobe_tx.sv
// tb_xclk_strobe_tx: scoreboard bench; far side echoes xreq back on xack after 5 clocks
module tb_xclk_strobe_tx;

    localparam int CNT_W = 4;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_stb = 1'b0;
    logic             stat_clr = 1'b0;
    logic             xreq, xack, busy, overflow, err;
    logic [CNT_W-1:0] pending;

    logic [4:0] dly = '0;
    logic       freeze = 1'b0;
    logic       hold = 1'b0;
    logic       stray = 1'b0;
    logic       exp_lvl = 1'b0;
    logic       last = 1'b0;
    logic       resync = 1'b0;
    logic       q[$];
    int         checks = 0;
    int         failures = 0;
    int         toggles = 0;

    always #5 clk = ~clk;

    always @(posedge clk) dly <= !rst_n ? 5'b0 : {dly[3:0], xreq};
    assign xack = (freeze ? hold : dly[4]) ^ stray;

    xclk_strobe_tx #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_stb   (in_stb),
        .xreq     (xreq),
        .xack     (xack),
        .pending  (pending),
        .busy     (busy),
        .stat_clr (stat_clr),
        .overflow (overflow),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stb(input bit acc);
        in_stb = 1'b1;
        if (acc) begin
            exp_lvl = !exp_lvl;
            q.push_back(exp_lvl);
        end
        tick();
        in_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
        tick();
        tick();
    endtask

    task automatic wait_pend(input int v);
        int n = 0;
        while (pending != v && n < 50) begin
            tick();
            n++;
        end
        chk("pend_step", pending, v);
    endtask

    always @(negedge clk) begin
        if (!rst_n || resync) begin
            last   = xreq;
            resync = 1'b0;
        end else if (xreq !== last) begin
            toggles++;
            chk("ack_order", xack, last);
            if (q.size() == 0) chk("unexp_toggle", 1, 0);
            else               chk("toggle_lvl", xreq, q.pop_front());
            last = xreq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        logic l0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_xreq", xreq, 0);
        chk("rst_pend", pending, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);
        repeat (6) tick();
        stb(1);
        chk("s1_xreq", xreq, 1);
        chk("s1_pend", pending, 0);
        chk("s1_busy", busy, 1);
        repeat (7) tick();
        chk("s1_busy_hold", busy, 1);
        tick();
        chk("s1_busy_low", busy, 0);
        chk("s1_ovf", overflow, 0);
        chk("s1_err", err, 0);
        tick();
        tick();
        t0 = toggles;
        repeat (4) stb(1);
        chk("b_pend_peak", pending, 3);
        wait_pend(2);
        wait_pend(1);
        wait_pend(0);
        wait_idle();
        chk("b_toggles", toggles - t0, 4);
        chk("b_ovf", overflow, 0);
        t0 = toggles;
        hold = xack;
        freeze = 1'b1;
        repeat (16) stb(1);
        chk("sat_pend16", pending, 15);
        chk("sat_ovf16", overflow, 0);
        stb(0);
        chk("sat_pend17", pending, 15);
        chk("sat_ovf17", overflow, 1);
        freeze = 1'b0;
        stat_clr = 1'b1;
        stb(0);
        stat_clr = 1'b0;
        chk("sat_ovf_setwins", overflow, 1);
        chk("sat_pend18", pending, 15);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("sat_ovf_clr", overflow, 0);
        wait_idle();
        chk("sat_toggles", toggles - t0, 16);
        repeat (3) stb(1);
        l0 = xreq;
        chk("sim_pend_wait", pending, 2);
        repeat (6) tick();
        chk("sim_pend_pre", pending, 2);
        chk("sim_xreq_pre", xreq, l0);
        stb(1);
        chk("sim_pend_post", pending, 2);
        chk("sim_xreq_post", xreq, !l0);
        wait_idle();
        t0 = toggles;
        l0 = xreq;
        stray = 1'b1;
        tick();
        tick();
        chk("stray_err_early", err, 0);
        tick();
        chk("stray_err", err, 1);
        chk("stray_busy", busy, 0);
        chk("stray_xreq", xreq, l0);
        stray = 1'b0;
        repeat (4) tick();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stray_err_clr", err, 0);
        chk("stray_toggles", toggles - t0, 0);
        repeat (4) stb(1);
        chk("mr_pend_pre", pending, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        exp_lvl = 1'b0;
        resync = 1'b1;
        chk("mr_pend", pending, 0);
        chk("mr_xreq", xreq, 0);
        chk("mr_busy", busy, 0);
        tick();
        stb(1);
        chk("mr_xreq_launch", xreq, 1);
        wait_idle();
        chk("mr_err", err, 0);
        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
